// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage types, bubble encoding and reset PC shared across the pipeline
package cpu_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, READY, DROP} fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'hFC00_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_pc_sel.sv
// if_pc_sel: next-PC mux (branch > jump > sequential) with word-aligned targets
module if_pc_sel
    import cpu_pkg::*;
(
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] seq_base_i,
    output logic [31:0] seq_pc_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] w_seq;

    assign w_seq    = seq_base_i + 32'd4;
    assign seq_pc_o = w_seq;

    // Branch wins over jump; redirect targets have their byte offset stripped
    always_comb begin
        next_pc_o = branch_taken_i ? word_align(branch_target_i) :
                    jump_i         ? word_align(jump_target_i)   : w_seq;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction-memory requester feeding the IF/ID register
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hd_i,
    input  logic        memstall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        flush_o
);

    fetch_state_t r_state;
    logic         r_req;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_inst;
    logic [31:0]  r_inst_addr;
    logic         w_stall;
    logic         w_redirect;
    logic [31:0]  w_seq_pc;
    logic [31:0]  w_next_pc;

    assign w_stall     = hd_i | memstall_i;
    assign w_redirect  = (branch_taken_i | jump_i) & ~w_stall;
    assign flush_o     = w_redirect;
    assign imem_req_o  = r_req;
    assign imem_addr_o = r_req_addr;
    assign inst_o      = r_inst;
    assign inst_addr_o = r_inst_addr;

    if_pc_sel u_pc_sel (
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .seq_base_i      (r_req_addr),
        .seq_pc_o        (w_seq_pc),
        .next_pc_o       (w_next_pc)
    );

    // Fetch FSM; r_inst doubles as the fetch buffer and is NOP_INST outside READY
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_inst      <= NOP_INST;
            r_inst_addr <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state    <= FETCH;
                        r_req      <= 1'b1;
                        r_req_addr <= r_pc;
                    end
                end
                FETCH: begin
                    if (imem_ack_i && w_redirect) begin
                        r_pc       <= w_next_pc;
                        r_req_addr <= w_next_pc;
                    end else if (imem_ack_i) begin
                        r_state     <= READY;
                        r_req       <= 1'b0;
                        r_inst      <= imem_data_i;
                        r_inst_addr <= w_seq_pc;
                        r_pc        <= w_seq_pc;
                    end else if (w_redirect) begin
                        r_state <= DROP;
                        r_pc    <= w_next_pc;
                    end
                end
                READY: begin
                    if (w_redirect || !w_stall) begin
                        r_state    <= FETCH;
                        r_req      <= 1'b1;
                        r_inst     <= NOP_INST;
                        r_pc       <= w_redirect ? w_next_pc : r_pc;
                        r_req_addr <= w_redirect ? w_next_pc : r_pc;
                    end
                end
                DROP: begin
                    if (w_redirect)
                        r_pc <= w_next_pc;
                    if (imem_ack_i) begin
                        r_state    <= FETCH;
                        r_req_addr <= w_redirect ? w_next_pc : r_pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus randomized program-order check of the fetch stage
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst, start, hd, ms, br, jp, ack;
    logic [31:0] bt, jt, data;
    logic        req, flush;
    logic [31:0] addr, inst, iaddr;

    int total = 0;
    int bad = 0;
    int lat = 0;
    int cnt = 0;
    bit rand_lat = 1'b0;

    if_fetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .hd_i            (hd),
        .memstall_i      (ms),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .jump_i          (jp),
        .jump_target_i   (jt),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ack_i      (ack),
        .imem_data_i     (data),
        .inst_o          (inst),
        .inst_addr_o     (iaddr),
        .flush_o         (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h8C22_0000 ^ a;
    endfunction

    task automatic drive_mem();
        if (req === 1'b1 && cnt >= lat) begin
            ack  = 1'b1;
            data = memw(addr);
        end else begin
            ack  = 1'b0;
            data = $urandom;
        end
    endtask

    task automatic cyc();
        logic req_s, ack_s;
        req_s = req;
        ack_s = ack;
        @(posedge clk);
        if (req_s && ack_s) begin
            cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end else if (req_s) cnt++;
        @(negedge clk);
        drive_mem();
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        cnt = 0;
        ack = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%h want=0", req); end
        total++; if (inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h want=%h", inst, NOP); end
        total++; if (iaddr !== 32'd0) begin bad++; $display("FAIL reset_iaddr got=%h want=0", iaddr); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%h want=0", flush); end
        rst = 1'b0;
        cyc();
        cyc();
        total++; if (req !== 1'b0) begin bad++; $display("FAIL idle_no_start_req got=%h want=0", req); end
    endtask

    task automatic test_sequential();
        lat = 0;
        restart();
        for (int k = 0; k < 3; k++) begin
            total++; if (req !== 1'b1 || addr !== 32'(4 * k)) begin bad++; $display("FAIL seq_req%0d got=%h/%h want=1/%h", k, req, addr, 32'(4 * k)); end
            total++; if (inst !== NOP) begin bad++; $display("FAIL seq_bubble%0d got=%h want=%h", k, inst, NOP); end
            cyc();
            total++; if (inst !== memw(32'(4 * k)) || iaddr !== 32'(4 * k + 4)) begin bad++; $display("FAIL seq_inst%0d got=%h/%h want=%h/%h", k, inst, iaddr, memw(32'(4 * k)), 32'(4 * k + 4)); end
            total++; if (req !== 1'b0) begin bad++; $display("FAIL seq_ready_req%0d got=%h want=0", k, req); end
            cyc();
        end
    endtask

    task automatic test_stall();
        lat = 0;
        restart();
        cyc();
        cyc();
        cyc();
        ms = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if (inst !== 32'h8C22_0004 || iaddr !== 32'h8 || req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%h want=8c220004/8/0", k, inst, iaddr, req); end
            if (k == 2) ms = 1'b0;
            else cyc();
        end
        cyc();
        total++; if (req !== 1'b1 || addr !== 32'h8) begin bad++; $display("FAIL stall_resume got=%h/%h want=1/8", req, addr); end
    endtask

    task automatic test_branch();
        lat = 0;
        restart();
        cyc();
        br = 1'b1;
        bt = 32'h40;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush got=%h want=1", flush); end
        cyc();
        br = 1'b0;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL br_flush_drop got=%h want=0", flush); end
        total++; if (req !== 1'b1 || addr !== 32'h40 || inst !== NOP) begin bad++; $display("FAIL br_req got=%h/%h/%h want=1/40/%h", req, addr, inst, NOP); end
        cyc();
        total++; if (inst !== memw(32'h40) || iaddr !== 32'h44) begin bad++; $display("FAIL br_inst got=%h/%h want=%h/44", inst, iaddr, memw(32'h40)); end
        cyc();
    endtask

    task automatic test_jump_drop();
        lat = 2;
        restart();
        jp = 1'b1;
        jt = 32'h100;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL jp_flush got=%h want=1", flush); end
        cyc();
        jp = 1'b0;
        total++; if (req !== 1'b1 || addr !== 32'h0 || inst !== NOP) begin bad++; $display("FAIL drop_hold got=%h/%h/%h want=1/0/%h", req, addr, inst, NOP); end
        cyc();
        total++; if (ack !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL drop_ack got=%h/%h want=1/0", ack, addr); end
        cyc();
        total++; if (req !== 1'b1 || addr !== 32'h100 || inst !== NOP) begin bad++; $display("FAIL drop_refetch got=%h/%h/%h want=1/100/%h", req, addr, inst, NOP); end
        lat = 0;
        for (int i = 0; i < 10 && inst === NOP; i++) cyc();
        total++; if (inst !== memw(32'h100) || iaddr !== 32'h104) begin bad++; $display("FAIL jp_inst got=%h/%h want=%h/104", inst, iaddr, memw(32'h100)); end
        cyc();
    endtask

    task automatic test_priority();
        lat = 0;
        restart();
        cyc();
        br = 1'b1;
        bt = 32'h40;
        jp = 1'b1;
        jt = 32'h100;
        cyc();
        br = 1'b0;
        jp = 1'b0;
        total++; if (req !== 1'b1 || addr !== 32'h40) begin bad++; $display("FAIL prio_addr got=%h/%h want=1/40", req, addr); end
        cyc();
        hd = 1'b1;
        br = 1'b1;
        jp = 1'b1;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL hd_flush got=%h want=0", flush); end
        cyc();
        total++; if (inst !== memw(32'h40) || iaddr !== 32'h44 || req !== 1'b0) begin bad++; $display("FAIL hd_hold got=%h/%h/%h want=%h/44/0", inst, iaddr, req, memw(32'h40)); end
        hd = 1'b0;
        br = 1'b0;
        jp = 1'b0;
        cyc();
        total++; if (req !== 1'b1 || addr !== 32'h44) begin bad++; $display("FAIL hd_pc got=%h/%h want=1/44", req, addr); end
        cyc();
    endtask

    task automatic test_wrap();
        lat = 0;
        restart();
        cyc();
        br = 1'b1;
        bt = 32'hFFFF_FFFF;
        cyc();
        br = 1'b0;
        total++; if (addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%h want=fffffffc", addr); end
        cyc();
        total++; if (iaddr !== 32'h0 || inst !== memw(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_pc4 got=%h/%h want=0/%h", iaddr, inst, memw(32'hFFFF_FFFC)); end
        cyc();
        total++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h/%h want=1/0", req, addr); end
        cyc();
    endtask

    task automatic test_reset_mid();
        lat = 0;
        restart();
        cyc();
        br = 1'b1;
        bt = 32'h20;
        lat = 5;
        cyc();
        br = 1'b0;
        total++; if (req !== 1'b1 || addr !== 32'h20) begin bad++; $display("FAIL rmid_pre got=%h/%h want=1/20", req, addr); end
        rst = 1'b1;
        #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rmid_async got=%h want=0", req); end
        cyc();
        rst = 1'b0;
        cnt = 0;
        lat = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL rmid_restart got=%h/%h want=1/0", req, addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, last_addr;
        logic        last_req, last_ack, stall, er;
        int          delivered;
        rand_lat = 1'b1;
        lat = $urandom_range(0, 3);
        restart();
        exp_pc = 32'h0;
        delivered = 0;
        last_req = 1'b0;
        last_ack = 1'b0;
        last_addr = 32'h0;
        for (int n = 0; n < 800; n++) begin
            hd    = ($urandom_range(0, 9) == 0);
            ms    = ($urandom_range(0, 9) == 0);
            br    = ($urandom_range(0, 11) == 0);
            jp    = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 7) == 0);
            bt    = $urandom & 32'h0000_FFFF;
            jt    = $urandom & 32'h0000_FFFF;
            #1;
            stall = hd | ms;
            er = (br | jp) & ~stall;
            total++; if (flush !== er) begin bad++; $display("FAIL rnd_flush cyc%0d got=%h want=%h", n, flush, er); end
            if (last_req && !last_ack) begin
                total++; if (req !== 1'b1 || addr !== last_addr) begin bad++; $display("FAIL rnd_req_hold cyc%0d got=%h/%h want=1/%h", n, req, addr, last_addr); end
            end
            if (er) exp_pc = (br ? bt : jt) & 32'hFFFF_FFFC;
            else if (inst !== NOP && !stall) begin
                total++; if (inst !== memw(exp_pc) || iaddr !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_inst cyc%0d got=%h/%h want=%h/%h", n, inst, iaddr, memw(exp_pc), exp_pc + 32'd4); end
                exp_pc += 32'd4;
                delivered++;
            end
            last_req = req;
            last_ack = ack;
            last_addr = addr;
            cyc();
        end
        {hd, ms, br, jp, start} = '0;
        rand_lat = 1'b0;
        total++; if (delivered < 20) begin bad++; $display("FAIL rnd_progress got=%0d want>=20", delivered); end
    endtask

    initial begin
        rst = 1'b1;
        {start, hd, ms, br, jp, ack} = '0;
        bt = 32'h0;
        jt = 32'h0;
        data = 32'h0;
        @(negedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_drop();
        test_priority();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the producer that feeds the IF/ID pipeline register.
- Owns the PC and drives a multi-cycle instruction-memory request/acknowledge interface.
- Presents fetched instruction, PC+4 and a flush strobe to IF/ID.
- Holds its instruction under hazard/D-cache stall; applies branch/jump redirects from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'hFC00_0000, bubble encoding; matches the IF/ID flush encoding.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin fetching; sampled only in IDLE.
- hd_i  in  1  load-use hazard stall from the hazard unit.
- memstall_i  in  1  D-cache miss stall.
- branch_taken_i  in  1  branch resolved taken in ID.
- branch_target_i  in  32  branch target.
- jump_i  in  1  jump in ID.
- jump_target_i  in  32  jump target.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  32  request address; stable while imem_req_o=1.
- imem_ack_i  in  1  request complete; imem_data_i valid this cycle.
- imem_data_i  in  32  instruction word.
- inst_o  out  32  instruction to IF/ID; NOP_INST when none is valid.
- inst_addr_o  out  32  fetched PC+4 to IF/ID.
- flush_o  out  1  redirect accepted; IF/ID loads a bubble.

Behaviour:
- stall = hd_i | memstall_i.
- redirect = (branch_taken_i | jump_i) & ~stall.
  - Branch target has priority when branch and jump are both high.
  - Redirects are ignored while stall=1.
- flush_o = redirect (combinational).
- Reset (async):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC, buffer invalid.
  - imem_req_o=0, inst_o=NOP_INST, inst_addr_o=0, flush_o=0.
- States: IDLE, FETCH, READY, DROP.
- IDLE:
  - imem_req_o=0.
  - start_i=1 -> FETCH next cycle, req_addr<=pc.
- FETCH:
  - imem_req_o=1, imem_addr_o=req_addr.
  - No ack, no redirect: stay in FETCH.
  - Ack, no redirect: buf<=imem_data_i; buf_pc4<=req_addr+4; pc<=req_addr+4 -> READY.
  - Ack with redirect: discard data; pc<=target, req_addr<=target; stay in FETCH (new request next cycle).
  - No ack with redirect: pc<=target -> DROP. The outstanding request is never abandoned.
- READY:
  - inst_o=buf, inst_addr_o=buf_pc4, imem_req_o=0.
  - stall=1: hold everything; outputs stable.
  - stall=0, no redirect: IF/ID captures buf at this edge -> FETCH, req_addr<=pc.
  - redirect: buf dropped (IF/ID loads bubble via flush_o); pc<=target, req_addr<=target -> FETCH.
- DROP:
  - imem_req_o=1 with the old req_addr.
  - On ack: discard data; req_addr<=pc -> FETCH.
  - A further redirect in DROP updates pc only (latest redirect wins).
- inst_o=NOP_INST in every state except READY. inst_addr_o holds its last value.
- Minimum fetch throughput with zero-wait ack: one instruction per 2 cycles (FETCH, READY).
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0. Low two bits of the target are forced to 0.
- Reset asserted mid-request: imem_req_o drops immediately. The memory side must tolerate an abandoned request on reset only.
- start_i is ignored outside IDLE.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state enum {IDLE, FETCH, READY, DROP}.
  - NOP_INST constant (shared with IF/ID flush).
  - RESET_PC default.
- One natural sub-module: if_pc_sel, combinational next-PC/target mux (branch > jump > sequential) plus word-alignment masking.

Test Plan:
- Reset, start_i pulse, ack one cycle after every req -> imem_addr_o sequence 0x0, 0x4, 0x8. inst_o shows each word for one cycle with inst_addr_o 0x4, 0x8, 0xC, and NOP_INST in between.
- memstall_i=1 for 3 cycles while READY with inst 0x8C220004 -> inst_o and inst_addr_o stable all 3 cycles, imem_req_o=0. The next req goes out one cycle after stall drops.
- branch_taken_i=1, target 0x40, in READY -> flush_o=1 for exactly that cycle. Next imem_addr_o=0x40 and the buffered inst never reaches IF/ID.
- jump_i=1, target 0x100, in FETCH with ack 2 cycles later -> DROP holds the old address, returned data is discarded (inst_o=NOP_INST). The next request address is 0x100.
- branch_taken_i and jump_i both high (0x40 vs 0x100) -> 0x40 fetched. Repeat with hd_i=1 -> flush_o=0 and the PC is unchanged.
- rst_i asserted mid-FETCH at 0x20 -> imem_req_o=0 without waiting for a clock edge. After release and start_i, the first request address is RESET_PC.
